pc_ctrl: RTL and testbench

PC_CTRL -- requirements
Module: pc_ctrl

---
 rtl/pc_ctrl.sv | 139 +++++++++++++
 tb/tb_pc_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_ctrl.sv
// pc_ctrl: fetch-stage PC control FSM (IDLE / RUN / FLUSH / HALT).
// Parameters: FLUSH_CYCLES (1..7) cycles of flush per taken branch,
//             CNT_WIDTH width of the stalled-cycle counter.
// Ports: clk, rst (sync, active-high), trigger (run enable), stall,
//        branch_taken, halt -> pc_en, pcsrc, flush (combinational),
//        state (registered FSM encoding), stall_cnt (only with PC_CTRL_PERF_EN).
// Optional feature macro: PC_CTRL_PERF_EN enables the stall_cnt port/counter.
module pc_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_WIDTH    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trigger,
  input  logic       stall,
  input  logic       branch_taken,
  input  logic       halt,
  output logic       pc_en,
  output logic       pcsrc,
  output logic       flush,
  output logic [1:0] state
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt
`endif
);

  localparam int unsigned FCNT_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

`ifdef PC_CTRL_PERF_EN
  logic                 stall_hit;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
`endif

  // Next-state, flush counter and combinational outputs.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pc_en   = 1'b0;
    pcsrc   = 1'b0;
    flush   = 1'b0;
`ifdef PC_CTRL_PERF_EN
    stall_hit = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (trigger) state_d = RUN;
      end
      RUN: begin
        if (!trigger) begin
          flush   = 1'b1;
          state_d = IDLE;
        end else if (branch_taken) begin
          // Redirect now; extra flush cycles only when FLUSH_CYCLES > 1.
          pc_en = 1'b1;
          pcsrc = 1'b1;
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
          end
        end else if (halt) begin
          state_d = HALT;
        end else if (stall) begin
`ifdef PC_CTRL_PERF_EN
          stall_hit = 1'b1;
`endif
        end else begin
          pc_en = 1'b1;
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (!trigger) begin
          state_d = IDLE;
          fcnt_d  = '0;
        end else begin
          pc_en  = 1'b1;
          fcnt_d = fcnt_q - FCNT_W'(1);
          if (fcnt_q <= FCNT_W'(1)) begin
            state_d = RUN;
            fcnt_d  = '0;
          end
        end
      end
      HALT: begin
      end
      default: begin
        state_d = IDLE;
        fcnt_d  = '0;
      end
    endcase
    // Reset forces the PC controls quiet for the whole reset cycle.
    if (rst) begin
      pc_en = 1'b0;
      pcsrc = 1'b0;
      flush = 1'b0;
    end
  end

  // State and flush counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign state = state_q;

`ifdef PC_CTRL_PERF_EN
  // Saturating count of RUN cycles resolved as a stall.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_hit && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Randomized self-checking bench for pc_ctrl: three instances with different
// FLUSH_CYCLES/CNT_WIDTH share one stimulus stream and are checked against a
// cycle-level behavioural model (mode + remaining flush cycles + stall count).
module tb_pc_ctrl;

  localparam int NI = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLUSH = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst, trigger, stall, branch_taken, halt;
  logic       en  [NI];
  logic       src [NI];
  logic       fl  [NI];
  logic [1:0] st  [NI];

  int fc [NI] = '{1, 2, 5};
  longint smax [NI] = '{3, 64'h0000_0000_FFFF_FFFF, 7};

  int     m_mode [NI];
  int     m_rem  [NI];
  longint m_sc   [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef PC_CTRL_PERF_EN
  logic [1:0]  sc0;
  logic [31:0] sc1;
  logic [2:0]  sc2;
`endif

  pc_ctrl #(.FLUSH_CYCLES(1), .CNT_WIDTH(2)) u0 (
    .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(en[0]), .pcsrc(src[0]), .flush(fl[0]), .state(st[0])
`ifdef PC_CTRL_PERF_EN
    , .stall_cnt(sc0)
`endif
  );

  pc_ctrl #(.FLUSH_CYCLES(2), .CNT_WIDTH(32)) u1 (
    .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(en[1]), .pcsrc(src[1]), .flush(fl[1]), .state(st[1])
`ifdef PC_CTRL_PERF_EN
    , .stall_cnt(sc1)
`endif
  );

  pc_ctrl #(.FLUSH_CYCLES(5), .CNT_WIDTH(3)) u2 (
    .clk(clk), .rst(rst), .trigger(trigger), .stall(stall),
    .branch_taken(branch_taken), .halt(halt),
    .pc_en(en[2]), .pcsrc(src[2]), .flush(fl[2]), .state(st[2])
`ifdef PC_CTRL_PERF_EN
    , .stall_cnt(sc2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check every instance, then advance the model.
  task automatic step(input logic r, input logic t, input logic s, input logic b, input logic h);
    logic e_en, e_src, e_fl;
    rst = r; trigger = t; stall = s; branch_taken = b; halt = h;
    #1;
    for (int i = 0; i < NI; i++) begin
      e_en = 1'b0; e_src = 1'b0; e_fl = 1'b0;
      if (!r) begin
        case (m_mode[i])
          M_RUN: begin
            if (!t)      e_fl = 1'b1;
            else if (b)  begin e_en = 1'b1; e_src = 1'b1; e_fl = 1'b1; end
            else if (h)  ;
            else if (s)  ;
            else         e_en = 1'b1;
          end
          M_FLUSH: begin e_fl = 1'b1; e_en = t; end
          default: ;
        endcase
      end
      check($sformatf("pc_en[%0d]", i), 32'(en[i]), 32'(e_en));
      check($sformatf("pcsrc[%0d]", i), 32'(src[i]), 32'(e_src));
      check($sformatf("flush[%0d]", i), 32'(fl[i]), 32'(e_fl));
      if (m_mode[i] >= 0) check($sformatf("state[%0d]", i), 32'(st[i]), 32'(m_mode[i]));
`ifdef PC_CTRL_PERF_EN
      if (m_mode[i] >= 0) begin
        case (i)
          0: check("stall_cnt[0]", 32'(sc0), 32'(m_sc[0]));
          1: check("stall_cnt[1]", sc1, 32'(m_sc[1]));
          default: check("stall_cnt[2]", 32'(sc2), 32'(m_sc[2]));
        endcase
      end
`endif
      // Model update for the coming edge.
      if (r) begin
        m_mode[i] = M_IDLE; m_rem[i] = 0; m_sc[i] = 0;
      end else begin
        case (m_mode[i])
          M_IDLE: if (t) m_mode[i] = M_RUN;
          M_RUN: begin
            if (!t) m_mode[i] = M_IDLE;
            else if (b) begin
              m_rem[i]  = fc[i] - 1;
              m_mode[i] = (m_rem[i] > 0) ? M_FLUSH : M_RUN;
            end else if (h) m_mode[i] = M_HALT;
            else if (s && m_sc[i] < smax[i]) m_sc[i]++;
          end
          M_FLUSH: begin
            if (!t) begin m_mode[i] = M_IDLE; m_rem[i] = 0; end
            else begin
              m_rem[i]--;
              if (m_rem[i] == 0) m_mode[i] = M_RUN;
            end
          end
          default: ;
        endcase
      end
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin m_mode[i] = -1; m_rem[i] = 0; m_sc[i] = 0; end
    rst = 1'b1; trigger = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    @(negedge clk);
    // Reset for two cycles, then start running.
    step(1, 0, 0, 0, 0); step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0); step(0, 1, 0, 0, 0);
    // Single taken branch and its flush tail.
    step(0, 1, 0, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 0, 0, 0);
    // Three stalls, then stall together with a branch.
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 1, 0);
    for (int k = 0; k < 6; k++) step(0, 1, 1, 0, 0);
    // Halt holds despite trigger and stimulus, left only by reset.
    step(0, 1, 0, 0, 1);
    for (int k = 0; k < 10; k++) step(0, 1, k[0], k[1], 0);
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    // Reset mid-flush, then trigger drop mid-flush.
    step(0, 1, 0, 1, 0); step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0); step(0, 1, 0, 1, 0); step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0); step(0, 0, 1, 0, 0);
    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 3),
           ($urandom_range(0, 99) < 90),
           ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 3));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
